// File: rtl/pauli_frame_tracker_if.sv
// ----------------------------------------------------------------------------
// pauli_frame_tracker_if
//   Bundles the decoder-facing correction inputs and the frame/readout outputs
//   of pauli_frame_tracker.
//
//   master : the upstream decoder / host side (drives corrections and
//            readout requests, observes frame, statistics and serial stream)
//   slave  : the tracker itself
//
//   Signals
//     correction [NQ]      one-hot correction, bit i = data qubit i
//     axis       [2]       00 idle, 01 X, 10 Y, 11 Z
//     clear                synchronous frame/statistics clear pulse
//     rd_start             request a serial snapshot readout
//     frame_x/frame_z[NQ]  current Pauli frame
//     sout/sout_valid/sout_last/rd_busy   serial readout
//     corr_count [COUNT_W] saturating count of applied nonzero corrections
//     multi_err            sticky multi-bit-correction flag
// ----------------------------------------------------------------------------
interface pauli_frame_tracker_if #(
    parameter int NQ      = 5,
    parameter int COUNT_W = 8
);
    logic [NQ-1:0]      correction;
    logic [1:0]         axis;
    logic               clear;
    logic               rd_start;
    logic [NQ-1:0]      frame_x;
    logic [NQ-1:0]      frame_z;
    logic               sout;
    logic               sout_valid;
    logic               sout_last;
    logic               rd_busy;
    logic [COUNT_W-1:0] corr_count;
    logic               multi_err;

    modport master (
        output correction, axis, clear, rd_start,
        input  frame_x, frame_z, sout, sout_valid, sout_last, rd_busy,
               corr_count, multi_err
    );

    modport slave (
        input  correction, axis, clear, rd_start,
        output frame_x, frame_z, sout, sout_valid, sout_last, rd_busy,
               corr_count, multi_err
    );
endinterface

// File: rtl/pauli_frame_tracker.sv
// ----------------------------------------------------------------------------
// pauli_frame_tracker
//   Accumulates decoder corrections into a Pauli frame (one X and one Z bit
//   per data qubit) instead of applying them physically. The frame is exposed
//   in parallel and through a serial snapshot readout, together with a
//   saturating count of applied corrections and a sticky flag for
//   non-one-hot corrections.
//
//   Ports
//     CLK   clock
//     RST   synchronous, active-high reset
//     bus   pauli_frame_tracker_if.slave (see interface header)
//
//   Serial readout: bit order frame_x[0..NQ-1], then frame_z[0..NQ-1].
//
//   Optional feature
//     FRAME_PARITY_EN : append an even-parity bit (XOR of the snapshot) as
//                       the final serial bit; sout_last moves onto it.
// ----------------------------------------------------------------------------
module pauli_frame_tracker #(
    parameter int NQ      = 5,
    parameter int COUNT_W = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    pauli_frame_tracker_if.slave  bus
);

`ifdef FRAME_PARITY_EN
    localparam int LEN = 2*NQ + 1;
`else
    localparam int LEN = 2*NQ;
`endif
    localparam int CW = $clog2(LEN + 1);

    localparam logic [1:0] AX_IDLE = 2'b00;
    localparam logic [1:0] AX_X    = 2'b01;
    localparam logic [1:0] AX_Y    = 2'b10;
    localparam logic [1:0] AX_Z    = 2'b11;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state;
    logic [NQ-1:0]      frame_x, frame_z;
    logic [COUNT_W-1:0] corr_count;
    logic               multi_err;
    logic [LEN-1:0]     snap;
    logic [LEN-1:0]     snap_next;
    logic [CW-1:0]      bit_cnt;
    logic               sout, sout_valid, sout_last, rd_busy;

    logic               active;
    logic               nonzero;
    logic               multi;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        active  = 1'b0;
        nonzero = 1'b0;
        multi   = 1'b0;
        active  = (bus.axis != AX_IDLE);
        nonzero = |bus.correction;
        // c & (c-1) clears the lowest set bit; anything left means >= 2 bits.
        multi   = |(bus.correction & (bus.correction - NQ'(1)));
    end

    // Snapshot taken from register values before the capturing edge, so a
    // same-edge frame update never appears in the stream.
    always_comb begin
        snap_next = '0;
`ifdef FRAME_PARITY_EN
        snap_next = {^{frame_z, frame_x}, frame_z, frame_x};
`else
        snap_next = {frame_z, frame_x};
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            frame_x    <= '0;
            frame_z    <= '0;
            corr_count <= '0;
            multi_err  <= 1'b0;
        end else if (bus.clear) begin
            // Clear wins; any same-cycle correction is discarded.
            frame_x    <= '0;
            frame_z    <= '0;
            corr_count <= '0;
            multi_err  <= 1'b0;
        end else begin
            if (bus.axis == AX_X || bus.axis == AX_Y)
                frame_x <= frame_x ^ bus.correction;
            if (bus.axis == AX_Z || bus.axis == AX_Y)
                frame_z <= frame_z ^ bus.correction;
            if (active && nonzero && (corr_count != '1))
                corr_count <= corr_count + COUNT_W'(1);
            if (active && multi)
                multi_err <= 1'b1;
        end
    end

    // Readout FSM. The first bit is driven on the capturing edge, so the
    // shift register holds only the bits still to come.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            snap       <= '0;
            bit_cnt    <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            sout_last  <= 1'b0;
            rd_busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.rd_start) begin
                        state      <= SHIFT;
                        snap       <= snap_next >> 1;
                        sout       <= snap_next[0];
                        sout_valid <= 1'b1;
                        sout_last  <= 1'b0;
                        rd_busy    <= 1'b1;
                        bit_cnt    <= CW'(1);
                    end
                end
                SHIFT: begin
                    if (bit_cnt == CW'(LEN)) begin
                        state      <= IDLE;
                        sout       <= 1'b0;
                        sout_valid <= 1'b0;
                        sout_last  <= 1'b0;
                        rd_busy    <= 1'b0;
                        bit_cnt    <= '0;
                    end else begin
                        sout      <= snap[0];
                        snap      <= snap >> 1;
                        bit_cnt   <= bit_cnt + CW'(1);
                        sout_last <= (bit_cnt == CW'(LEN - 1));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.frame_x    = frame_x;
    assign bus.frame_z    = frame_z;
    assign bus.corr_count = corr_count;
    assign bus.multi_err  = multi_err;
    assign bus.sout       = sout;
    assign bus.sout_valid = sout_valid;
    assign bus.sout_last  = sout_last;
    assign bus.rd_busy    = rd_busy;

endmodule
